// File: rtl/usb_ep_out_reader.sv
// +---------------------------------------------------------------------------+
// | usb_ep_out_reader: drains a USB1.1 bulk OUT endpoint FIFO onto a          |
// | valid/ready byte stream and runs the FIFO-clear (flush) handshake.        |
// | Optional received-byte counter: define USB_EP_RD_CNT_EN.   Rev 1.0        |
// +---------------------------------------------------------------------------+
`default_nettype none

module usb_ep_out_reader #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ep_dout,
  output logic             ep_re,
  input  logic [3:0]       ep_stat,
  input  logic             bulk_idle,
  output logic             clr_bulk,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int OW = AW + 2;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    WAIT_IDLE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_inflight;
  logic [7:0]    r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_discard;
  logic          w_issue;
  logic          w_flush_fin;
  logic [OW-1:0] w_pending;
  logic          unused_stat;

  assign unused_stat = ^{ep_stat[3:2], ep_stat[0]};

  assign w_push      = r_inflight;
  assign w_pop       = m_valid & m_ready;
  assign w_discard   = (r_state == DRAIN) && !ep_re && !r_inflight;
  assign w_flush_fin = (r_state == DONE) && clr_bulk;
  assign w_pending   = OW'(r_count) + OW'(r_inflight);

  // ep_re is registered, so the decision is made one cycle ahead; the
  // pending count covers every byte that can land before that read's data.
  assign w_issue = (r_state == RUN) && !flush_req && !ep_stat[1] && !ep_re &&
                   (w_pending < OW'(BUF_DEPTH));

  assign m_valid = (r_count != '0);
  assign m_data  = r_mem[r_rd_ptr];
  assign busy    = (r_state != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      ep_re      <= 1'b0;
      r_inflight <= 1'b0;
      clr_bulk   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      ep_re      <= w_issue;
      r_inflight <= ep_re;
      clr_bulk   <= 1'b0;
      flush_done <= 1'b0;
      case (r_state)
        RUN:       if (flush_req) r_state <= DRAIN;
        DRAIN:     if (!ep_re && !r_inflight) r_state <= WAIT_IDLE;
        WAIT_IDLE: begin
          if (bulk_idle) begin
            clr_bulk <= 1'b1;
            r_state  <= DONE;
          end
        end
        // Two cycles here: clr_bulk first, then flush_done, still busy.
        DONE: begin
          if (clr_bulk) flush_done <= 1'b1;
          else          r_state    <= RUN;
        end
        default:   r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= ep_dout;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_discard) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef USB_EP_RD_CNT_EN
  logic [CNT_W-1:0] r_byte_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt <= '0;
    end else if (w_flush_fin) begin
      r_byte_cnt <= '0;
    end else if (w_pop && (r_byte_cnt != {CNT_W{1'b1}})) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  assign byte_cnt = r_byte_cnt;
`else
  logic unused_fin;
  assign unused_fin = w_flush_fin;
  assign byte_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_ep_out_reader.sv
// Directed bench for usb_ep_out_reader with a small OUT endpoint FIFO model.
`default_nettype none

module tb_usb_ep_out_reader;

`ifdef USB_EP_RD_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ep_dout = 8'h00;
  logic       ep_re;
  logic [3:0] ep_stat;
  logic       bulk_idle = 1'b0;
  logic       clr_bulk;
  logic       flush_req = 1'b0;
  logic       flush_done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [3:0] byte_cnt;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fmem [256];
  int f_wr = 0;
  int f_rd = 0;

  usb_ep_out_reader #(.BUF_DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ep_dout(ep_dout), .ep_re(ep_re),
    .ep_stat(ep_stat), .bulk_idle(bulk_idle), .clr_bulk(clr_bulk),
    .flush_req(flush_req), .flush_done(flush_done), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .byte_cnt(byte_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core-side FIFO: data valid the cycle after ep_re, cleared by clr_bulk.
  assign ep_stat = {2'b00, (f_rd == f_wr), 1'b0};
  always @(posedge clk) begin
    if (clr_bulk) f_rd <= f_wr;
    else if (ep_re && (f_rd != f_wr)) begin
      ep_dout <= fmem[f_rd[7:0]];
      f_rd    <= f_rd + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    fmem[f_wr[7:0]] = b;
    f_wr = f_wr + 1;
  endtask

  task automatic do_reset;
    reset = 1'b0; m_ready = 1'b0; flush_req = 1'b0; bulk_idle = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
  endtask

  function automatic logic [3:0] exp_cnt(input int n);
    if (!CNT_ON) return 4'd0;
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    n_tests++;
    if ({ep_re, clr_bulk, flush_done, m_valid, busy} !== 5'b0 || m_data !== 8'h00 || byte_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: re=%b clr=%b done=%b valid=%b busy=%b data=%h cnt=%h, required all 0",
               ep_re, clr_bulk, flush_done, m_valid, busy, m_data, byte_cnt);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_stream;
    bit         exp_re [7] = '{1, 0, 1, 0, 1, 0, 0};
    bit         exp_v  [7] = '{0, 0, 1, 0, 1, 0, 1};
    logic [7:0] exp_d  [7] = '{8'h00, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
    m_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33);
    for (int c = 0; c < 7; c++) begin
      tick;
      n_tests++;
      if (ep_re !== exp_re[c] || m_valid !== exp_v[c] || (exp_v[c] && m_data !== exp_d[c])) begin
        n_fail++;
        $display("FAIL stream_c%0d: re=%b valid=%b data=%h, required re=%b valid=%b data=%h",
                 c, ep_re, m_valid, m_data, exp_re[c], exp_v[c], exp_d[c]);
      end
    end
    for (int c = 7; c < 11; c++) begin
      tick;
      n_tests++;
      if (ep_re !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_idle_c%0d: re=%b valid=%b, required 0 0", c, ep_re, m_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    int pulses = 0;
    int got = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(8'(i));
    for (int c = 0; c < 20; c++) begin
      tick;
      if (ep_re === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL bp_reads: %0d ep_re pulses, required 4", pulses);
    end
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h00 || ep_re !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b data=%h re=%b, required 1 00 0", m_valid, m_data, ep_re);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 80 && got < 8; c++) begin
      if (m_valid === 1'b1) begin
        n_tests++;
        if (m_data !== 8'(got)) begin
          n_fail++;
          $display("FAIL bp_order_%0d: data=%h, required %h", got, m_data, 8'(got));
        end
        got++;
      end
      tick;
    end
    n_tests++;
    if (got != 8 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_total: %0d bytes, valid=%b, required 8 bytes, valid 0", got, m_valid);
    end
  endtask

  task automatic test_push_pop;
    int got = 2;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(8'h40 + 8'(i));
    tick;
    n_tests++;
    if (ep_re !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_first_read: re=%b, required 1", ep_re);
    end
    for (int c = 1; c < 8; c++) tick;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h40 || ep_re !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_c7: valid=%b data=%h re=%b, required 1 40 0", m_valid, m_data, ep_re);
    end
    m_ready = 1'b1;
    tick;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h41 || ep_re !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_c8: valid=%b data=%h re=%b, required 1 41 0", m_valid, m_data, ep_re);
    end
    tick;
    n_tests++;
    if (ep_re !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_c9_read: re=%b, required 1", ep_re);
    end
    for (int c = 0; c < 60 && got < 8; c++) begin
      if (m_valid === 1'b1) begin
        n_tests++;
        if (m_data !== 8'h40 + 8'(got)) begin
          n_fail++;
          $display("FAIL pp_order_%0d: data=%h, required %h", got, m_data, 8'h40 + 8'(got));
        end
        got++;
      end
      tick;
    end
    n_tests++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL pp_total: %0d bytes, required 8", got);
    end
  endtask

  task automatic test_flush;
    int clr_seen = 0;
    m_ready = 1'b0; bulk_idle = 1'b0;
    load(8'h55); load(8'h66);
    tick;
    n_tests++;
    if (ep_re !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_read: re=%b, required 1", ep_re);
    end
    tick;
    flush_req = 1'b1;
    tick;
    flush_req = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h55 || busy !== 1'b1 || ep_re !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_c2: valid=%b data=%h busy=%b re=%b, required 1 55 1 0", m_valid, m_data, busy, ep_re);
    end
    for (int c = 3; c < 15; c++) begin
      tick;
      if (c == 8) bulk_idle = 1'b1;
      if (clr_bulk === 1'b1) clr_seen++;
      n_tests++;
      if (busy !== (c <= 10) || clr_bulk !== (c == 9) || flush_done !== (c == 10) ||
          m_valid !== 1'b0 || ep_re !== 1'b0) begin
        n_fail++;
        $display("FAIL fl_c%0d: busy=%b clr=%b done=%b valid=%b re=%b, required %b %b %b 0 0",
                 c, busy, clr_bulk, flush_done, m_valid, ep_re, (c <= 10), (c == 9), (c == 10));
      end
    end
    n_tests++;
    if (clr_seen != 1) begin
      n_fail++;
      $display("FAIL fl_clr_count: %0d clr_bulk pulses, required 1", clr_seen);
    end
    bulk_idle = 1'b0;
  endtask

  task automatic test_reset_mid_flush;
    int clr_seen = 0;
    int got = 0;
    logic [7:0] exp_b [2] = '{8'hA2, 8'h99};
    m_ready = 1'b0; bulk_idle = 1'b0;
    load(8'hA1); load(8'hA2);
    tick;
    tick;
    flush_req = 1'b1;
    tick;
    flush_req = 1'b0;
    tick; tick;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_busy_before: busy=%b, required 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({ep_re, clr_bulk, flush_done, m_valid, busy} !== 5'b0 || m_data !== 8'h00 || byte_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL rm_async: re=%b clr=%b done=%b valid=%b busy=%b data=%h cnt=%h, required all 0",
               ep_re, clr_bulk, flush_done, m_valid, busy, m_data, byte_cnt);
    end
    bulk_idle = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (clr_bulk === 1'b1) clr_seen++;
    end
    reset = 1'b1;
    m_ready = 1'b1;
    load(8'h99);
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (clr_bulk === 1'b1) clr_seen++;
      if (m_valid === 1'b1) begin
        n_tests++;
        if (m_data !== exp_b[got]) begin
          n_fail++;
          $display("FAIL rm_resume_%0d: data=%h, required %h", got, m_data, exp_b[got]);
        end
        got++;
      end
      tick;
    end
    n_tests++;
    if (clr_seen != 0 || got != 2) begin
      n_fail++;
      $display("FAIL rm_summary: clr pulses=%0d bytes=%0d, required 0 and 2", clr_seen, got);
    end
    bulk_idle = 1'b0;
  endtask

  task automatic test_byte_cnt;
    int n = 0;
    int waited = 0;
    do_reset;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) load(8'hC0 + 8'(i));
    for (int c = 0; c < 200 && n < 20; c++) begin
      tick;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (n == 10) begin
          n_tests++;
          if (byte_cnt !== exp_cnt(10)) begin
            n_fail++;
            $display("FAIL cnt_mid: byte_cnt=%0d, required %0d", byte_cnt, exp_cnt(10));
          end
        end
        n++;
      end
    end
    tick;
    n_tests++;
    if (n != 20 || byte_cnt !== exp_cnt(20)) begin
      n_fail++;
      $display("FAIL cnt_sat: transfers=%0d byte_cnt=%0d, required 20 and %0d", n, byte_cnt, exp_cnt(20));
    end
    flush_req = 1'b1;
    bulk_idle = 1'b1;
    tick;
    flush_req = 1'b0;
    while (flush_done !== 1'b1 && waited < 40) begin
      tick;
      waited++;
    end
    n_tests++;
    if (flush_done !== 1'b1 || byte_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL cnt_flush: flush_done=%b byte_cnt=%0d, required 1 and 0", flush_done, byte_cnt);
    end
    tick;
    n_tests++;
    if (byte_cnt !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_after: byte_cnt=%0d busy=%b, required 0 0", byte_cnt, busy);
    end
    bulk_idle = 1'b0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_push_pop;
    test_flush;
    test_reset_mid_flush;
    test_byte_cnt;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_ep_out_reader.md
Name: usb_ep_out_reader

Overview:
- Application-side reader for a USB1.1 bulk OUT endpoint FIFO: drains bytes from the core's OUT endpoint read port (ep_dout / ep_re / ep_stat).
- Presents the bytes on a valid/ready byte stream to user logic, buffering reads that are still in flight.
- Runs the FIFO-clear handshake with the core (bulk_idle / clr_bulk) on request from user logic.
- Instantiated beside usb1_top and wired to one OUT endpoint (ep2 or ep4).

Parameters:
BUF_DEPTH, 4, output skid-buffer entries; power of two, minimum 2.
CNT_W, 16, width of the received-byte counter.

Ports:
clk  input  1  system clock, same clock as the USB core
reset  input  1  asynchronous active-low reset
ep_dout  input  8  OUT endpoint FIFO read data, valid the cycle after ep_re
ep_re  output  1  OUT endpoint FIFO read strobe, one-cycle pulse
ep_stat  input  4  endpoint status; bit1 = FIFO empty, other bits ignored
bulk_idle  input  1  core reports bulk endpoints idle, so a FIFO clear is safe
clr_bulk  output  1  one-cycle FIFO clear pulse to the core
flush_req  input  1  user request to discard all pending OUT data (level, sampled)
flush_done  output  1  one-cycle pulse when a flush completes
m_data  output  8  stream byte
m_valid  output  1  stream valid
m_ready  input  1  stream ready
byte_cnt  output  CNT_W  bytes delivered on the stream (optional feature)
busy  output  1  high in any state other than RUN

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, buffer empty, no read in flight.
  - ep_re=0, clr_bulk=0, flush_done=0, m_valid=0, m_data=0, byte_cnt=0, busy=0.
- Read issue in RUN: ep_re=1 only when all of the following hold:
  - ep_stat[1]=0;
  - ep_re was 0 in the previous cycle (at most one read every 2 cycles, so empty status settles);
  - buffer occupancy + in-flight reads < BUF_DEPTH.
- Data capture: the cycle after ep_re=1, ep_dout is written into the buffer tail unconditionally. The issue rule guarantees space; the in-flight flag is cleared.
- Stream:
  - m_valid = buffer not empty; m_data = head entry, driven from a register.
  - Transfer when m_valid & m_ready; the head is popped.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - The buffer never drops bytes and never reorders them.
- Latency: with m_ready=1, the first byte appears on m_valid 2 cycles after the ep_re cycle (ep_re at t, capture at t+1, m_valid at t+2).
- Throughput: 1 byte every 2 cycles when the FIFO stays non-empty and m_ready=1.
- State machine:
  - RUN: normal operation. On flush_req=1 go to DRAIN; no new ep_re from this cycle onward.
  - DRAIN: wait until no read is in flight, then discard the buffer contents (occupancy=0, m_valid=0 the next cycle) and go to WAIT_IDLE.
  - WAIT_IDLE: wait for bulk_idle=1, then assert clr_bulk for exactly 1 cycle and go to DONE.
  - DONE: pulse flush_done for 1 cycle, then return to RUN. flush_req is ignored until RUN is re-entered. If flush_req is still high in RUN, a new flush starts.
- busy=1 in DRAIN, WAIT_IDLE and DONE.
- m_valid is not forced low in DRAIN until the discard, so a transfer that is already in progress completes. Byte_cnt counts only stream transfers.
- Reset mid-flush: everything returns to reset values and clr_bulk is not issued.
- ep_stat[1] toggling while a read is in flight has no effect on the capture of that read.

Optional Feature:
- Macro USB_EP_RD_CNT_EN.
- Defined:
  - byte_cnt increments by 1 on every stream transfer.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It is cleared to 0 when flush_done pulses, and on reset.
- Undefined: byte_cnt is tied to 0 and no counter logic is synthesised.

Test Plan:
1. FIFO preloaded with 0x11,0x22,0x33, m_ready=1 -> ep_re pulses at cycles 0,2,4; m_data 0x11,0x22,0x33 on m_valid at cycles 2,4,6; ep_re stays 0 once ep_stat[1]=1.
2. Backpressure: 8 bytes 0x00..0x07 in FIFO, m_ready=0 -> exactly 4 ep_re pulses, then ep_re stays 0 and m_valid holds 0x00. Release m_ready -> all 8 bytes arrive in order with no loss.
3. Simultaneous push/pop at full occupancy minus one (m_ready=1 during capture) -> occupancy constant, order preserved, no extra ep_re.
4. Flush: flush_req=1 the cycle after an ep_re, bulk_idle=0 for 5 cycles then 1 -> the captured byte is discarded, m_valid=0, and clr_bulk pulses once on the first cycle bulk_idle=1 is seen in WAIT_IDLE. flush_done follows 1 cycle later, and busy is high throughout.
5. Reset asserted in WAIT_IDLE -> clr_bulk never pulses; all outputs at reset values asynchronously; normal reads resume after release.
6. With USB_EP_RD_CNT_EN and CNT_W=4 -> 20 transfers give byte_cnt=15 (saturated); after a flush, byte_cnt=0. Without the macro, byte_cnt=0 throughout.
